immediate_former_pipelined: RTL
===============================

# immediate_former_pipelined

Parametrised, pipelined successor to the core's combinational LUI/AUIPC immediate former. It forms upper immediates, PC-relative sums, link addresses and branch/JALR targets from decoded operands. A valid/ready handshake carries operands in and results out, and the adder can optionally be split across two register stages for timing closure. It sits between decode and writeback/fetch-redirect in JZJCoreF, and it flags misaligned control-transfer targets.

## Interface
Parameters:
- XLEN, 32 — datapath width; legal values 32 or 64.
- SPLIT_ADD, 1 — 0: one register stage, full-width add; 1: two stages, low/high-half add with registered carry.
- ALIGN, 2 — log2 of required target alignment; 2 without C extension, 1 with it.

Ports:
- clock  in  1  — sole clock, rising edge.
- n_reset  in  1  — asynchronous, active-low reset.
- flush  in  1  — synchronous; discards every in-flight and same-cycle input transaction.
- in_valid  in  1  — operand bundle valid.
- in_ready  out  1  — block can accept this cycle.
- mode  in  3  — ImmFormMode_t: LUI, AUIPC, LINK, BRANCH_TGT, JALR_TGT.
- immediate  in  XLEN  — sign-extended immediate (U/J/B/I format pre-decoded).
- pc  in  XLEN  — PC of the instruction.
- rs1  in  XLEN  — register operand; used by JALR_TGT only.
- out_valid  out  1  — result valid.
- out_ready  in  1  — consumer accepts the result.
- result  out  XLEN  — formed value.
- misaligned  out  1  — target violates ALIGN; qualified by out_valid.

## Operation
- Transfer happens when valid && ready on the respective side. in_ready = !flush && (pipeline not full || output advancing).
- LUI: result = immediate.
- AUIPC, BRANCH_TGT: result = pc + immediate.
- LINK: result = pc + 4.
- JALR_TGT: result = (rs1 + immediate) & ~1.
- All sums are modulo 2^XLEN; carry-out is discarded (wrap-around is legal).
- misaligned = result[ALIGN-1:0] != 0, for BRANCH_TGT and JALR_TGT only; 0 for all other modes.
- Undefined mode encodings are accepted and produce result = 0, misaligned = 0. No X propagation.
- SPLIT_ADD=1:
  - Stage 1 adds the low XLEN/2 bits and registers the sum, the carry, the high operand halves and mode.
  - Stage 2 adds the high halves plus the carry.
  - The JALR bit-0 clear and the misaligned check are applied in stage 1 on the low half.
- Each stage holds a valid bit and a payload register. A stage loads when it is empty or its downstream accepts; otherwise it holds its value stably.
- flush: all stage valid bits are cleared on the next edge, and an input presented in the flush cycle is dropped. flush has priority over simultaneous accept and over out_ready.

## Timing
- Reset (n_reset low, asynchronous): all valid bits 0, result 0, misaligned 0, in_ready 1 after release (0 while flush is high).
- Latency from input accept to out_valid: 1 cycle (SPLIT_ADD=0) or 2 cycles (SPLIT_ADD=1).
- Throughput is one result per cycle while out_ready is high. There is no bubble between back-to-back transactions.
- When out_ready is low, the pipeline fills: after 1 or 2 accepted transactions, in_ready drops combinationally from pipeline state and out_ready.
- result and misaligned change only when a new value is loaded into the final stage.
- In-order delivery; no transaction is lost or duplicated except under flush or reset.
- Reset mid-operation discards all in-flight transactions. The first accepted input after reset behaves exactly as at power-up.

## Structure
- The ImmFormMode_t enum (3 bits; LUI=0, AUIPC=1, LINK=2, BRANCH_TGT=3, JALR_TGT=4) is added to JZJCoreFTypes.
- One sub-module: imm_former_stage, a generic valid/ready register slice with a payload width parameter. It is instantiated once or twice depending on SPLIT_ADD.
- The adder, mode decode and misaligned logic stay in the top module.

## Test plan
- LUI, immediate 0x12345000, out_ready=1 → result 0x12345000, misaligned 0, out_valid exactly 2 cycles after accept (SPLIT_ADD=1).
- AUIPC, pc 0x0000FFFC, immediate 0x00000004 → 0x00010000, which checks the split carry. Repeat with LINK, pc 0xFFFFFFFC → 0x00000000 (wrap).
- JALR_TGT, rs1 0x00001003, immediate 0 → result 0x00001002, misaligned 1 (ALIGN=2), and 0 when ALIGN=1. BRANCH_TGT, pc 0x100, immediate 0x8 → 0x108, misaligned 0.
- Three back-to-back inputs (AUIPC with immediates 1, 2, 3) with out_ready low for 5 cycles → in_ready deasserts after 2 accepts; after release, results appear in order with no loss.
- flush asserted while two transactions are in flight plus one input presented → out_valid 0 next cycle, nothing emitted, and the next input completes normally.
- n_reset pulsed low mid-stream → out_valid, result and misaligned go 0 immediately, and the first post-reset transaction returns the correct value with nominal latency.

Source files
------------

// File: rtl/immediate_former_pipelined_pkg.sv
// immediate_former_pipelined_pkg: mode encoding and helpers shared by the immediate former
package immediate_former_pipelined_pkg;
  typedef enum logic [2:0] {
    IMM_LUI        = 3'd0,
    IMM_AUIPC      = 3'd1,
    IMM_LINK       = 3'd2,
    IMM_BRANCH_TGT = 3'd3,
    IMM_JALR_TGT   = 3'd4
  } ImmFormMode_t;
  localparam int LINK_OFFSET = 4;
  function automatic logic mode_defined(input logic [2:0] m);
    return m <= IMM_JALR_TGT;
  endfunction
  function automatic logic is_target(input logic [2:0] m);
    return m == IMM_BRANCH_TGT || m == IMM_JALR_TGT;
  endfunction
endpackage

// File: rtl/immediate_former_pipelined_stage.sv
// imm_former_stage: valid/ready register slice carrying a W-bit payload
module imm_former_stage #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  // Next state: flush empties the slice; payload only changes on a real load so it stays stable while held.
  always_comb begin
    valid_d = flush ? 1'b0 : in_ready ? in_valid : valid_q;
    data_d  = (in_valid && in_ready && !flush) ? in_data : data_q;
  end
  // Slice registers with asynchronous clear.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/immediate_former_pipelined.sv
// immediate_former_pipelined: forms upper immediates, PC-relative sums, link and branch/JALR targets
module immediate_former_pipelined
  import immediate_former_pipelined_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int SPLIT_ADD = 1,
  parameter int ALIGN     = 2
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      mode,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            misaligned
);
  localparam int H = XLEN / 2;
  localparam logic [H-1:0] ALIGN_MASK = H'((1 << ALIGN) - 1);
  logic [XLEN-1:0] op_a, op_b;
  logic            jalr, tgt, s1_ready;
  // Undefined modes add zero to zero so they yield a clean 0 result.
  assign op_a = (mode == IMM_JALR_TGT) ? rs1
              : (mode == IMM_AUIPC || mode == IMM_LINK || mode == IMM_BRANCH_TGT) ? pc : '0;
  assign op_b = (mode == IMM_LINK) ? XLEN'(LINK_OFFSET) : mode_defined(mode) ? immediate : '0;
  assign jalr = mode == IMM_JALR_TGT;
  assign tgt  = is_target(mode);
  assign in_ready = !flush && s1_ready;
  if (SPLIT_ADD != 0) begin : g_split
    localparam int S1W = 3 * H + 5;
    logic [H:0]      lo_sum;
    logic [H-1:0]    lo_res, hi_sum, s1_hi_a, s1_hi_b, s1_lo;
    logic [S1W-1:0]  s1_in, s1_out;
    logic [XLEN:0]   s2_in, s2_out;
    logic [2:0]      s1_mode;
    logic            s1_mis, s1_carry, s1_valid, s2_ready;
    // Low half is final after stage 1, so JALR bit-0 clear and alignment check happen here.
    assign lo_sum = {1'b0, op_a[H-1:0]} + {1'b0, op_b[H-1:0]};
    assign lo_res = lo_sum[H-1:0] & ~H'(jalr);
    assign s1_in  = {mode, tgt && |(lo_res & ALIGN_MASK), lo_sum[H], op_a[XLEN-1:H], op_b[XLEN-1:H], lo_res};
    imm_former_stage #(.W(S1W)) u_s1 (
      .clock(clock), .n_reset(n_reset), .flush(flush),
      .in_valid(in_valid), .in_ready(s1_ready), .in_data(s1_in),
      .out_valid(s1_valid), .out_ready(s2_ready), .out_data(s1_out)
    );
    assign {s1_mode, s1_mis, s1_carry, s1_hi_a, s1_hi_b, s1_lo} = s1_out;
    assign hi_sum = mode_defined(s1_mode) ? s1_hi_a + s1_hi_b + H'(s1_carry) : '0;
    assign s2_in  = {s1_mis, hi_sum, s1_lo};
    imm_former_stage #(.W(XLEN + 1)) u_s2 (
      .clock(clock), .n_reset(n_reset), .flush(flush),
      .in_valid(s1_valid), .in_ready(s2_ready), .in_data(s2_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(s2_out)
    );
    assign {misaligned, result} = s2_out;
  end else begin : g_single
    logic [XLEN-1:0] sum;
    logic [XLEN:0]   s_in, s_out;
    assign sum  = (op_a + op_b) & ~XLEN'(jalr);
    assign s_in = {tgt && |(sum[H-1:0] & ALIGN_MASK), sum};
    imm_former_stage #(.W(XLEN + 1)) u_s (
      .clock(clock), .n_reset(n_reset), .flush(flush),
      .in_valid(in_valid), .in_ready(s1_ready), .in_data(s_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(s_out)
    );
    assign {misaligned, result} = s_out;
  end
endmodule
